// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  // Step counter must hold WIDTH-1 with headroom.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative HI/LO multiply/divide unit: magnitudes in, one step per cycle,
// sign correction in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             div0p_q, div0p_d, div0_q, div0_d, done_q, done_d;

  logic             sgn_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign rs_neg = sgn_op & rs_i[WIDTH-1];
  assign rt_neg = sgn_op & rt_i[WIDTH-1];

  muldiv_negate #(.W(WIDTH)) u_neg_rs (.val_i(rs_i), .neg_i(rs_neg), .res_o(rs_mag));
  muldiv_negate #(.W(WIDTH)) u_neg_rt (.val_i(rt_i), .neg_i(rt_neg), .res_o(rt_mag));
  muldiv_negate #(.W(2*WIDTH)) u_neg_prod (.val_i({acc_q, sh_q}), .neg_i(neg_res_q), .res_o(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_neg_quo (.val_i(sh_q), .neg_i(neg_res_q), .res_o(quo_fix));
  muldiv_negate #(.W(WIDTH)) u_neg_rem (.val_i(acc_q), .neg_i(neg_rem_q), .res_o(rem_fix));

  // Shared adder: multiply adds the multiplicand when the low multiplier bit is set;
  // divide subtracts the divisor from {rem, next dividend bit}, carry-out = no borrow.
  logic [WIDTH:0]   add_a, add_b;
  logic [WIDTH+1:0] add_s;

  assign add_a = is_div_q ? {acc_q, sh_q[WIDTH-1]} : {1'b0, acc_q};
  assign add_b = is_div_q ? ~{1'b0, opb_q} : (sh_q[0] ? {1'b0, opb_q} : '0);
  assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0p_d   = div0p_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = S_CALC;
              cnt_d     = '0;
              is_div_d  = op_i[1];
              acc_d     = '0;
              sh_d      = rs_mag;
              opb_d     = rt_mag;
              neg_res_d = rs_neg ^ rt_neg;
              neg_rem_d = rs_neg;
              div0p_d   = (rt_i == '0);
            end
            OP_MTHI: hi_d = rs_i;
            OP_MTLO: lo_d = rs_i;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            sh_d  = {sh_q[WIDTH-2:0], add_s[WIDTH+1]};
            acc_d = add_s[WIDTH+1] ? add_s[WIDTH-1:0] : add_a[WIDTH-1:0];
          end else begin
            acc_d = add_s[WIDTH:1];
            sh_d  = {add_s[0], sh_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // A zero divisor leaves the dividend in the remainder; only LO needs forcing.
            hi_d   = rem_fix;
            lo_d   = div0p_q ? '1 : quo_fix;
            div0_d = div0p_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0p_q   <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0p_q   <= div0p_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign div0_o = div0_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk, rst, start_i, flush_i, busy_o, done_o, div0_o;
  logic [2:0]   op_i;
  logic [W-1:0] rs_i, rt_i, hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .op_i(op_i), .rs_i(rs_i),
    .rt_i(rt_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
    .div0_o(div0_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
  endtask

  // Cycles from the start cycle (accept edge = 1) until done_o is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (n == 1) start_i = 1'b0;
      if (done_o) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (div0_o !== 1'b0) begin errors++; $display("FAIL reset_div0 got=%b exp=0", div0_o); end
    checks++; if ({hi_o, lo_o} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi_o, lo_o}); end
    step(); rst = 1'b0; step();
  endtask

  task automatic test_mult();
    int lat;
    drive(3'b000, 32'hFFFF_FFFD, 32'd7); wait_done(lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency got=%0d exp=34", lat); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo_o); end
    step();
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b%b exp=00", done_o, busy_o); end
    drive(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(lat);
    checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got=%h exp=fffffffe00000001", {hi_o, lo_o}); end
    step();
  endtask

  task automatic test_div0();
    int lat;
    drive(3'b011, 32'd100, 32'd0); wait_done(lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL div0_latency got=%0d exp=34", lat); end
    checks++; if ({hi_o, lo_o} !== {32'h64, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_zero got=%h exp=00000064ffffffff", {hi_o, lo_o}); end
    checks++; if (div0_o !== 1'b1) begin errors++; $display("FAIL div0_set got=%b exp=1", div0_o); end
    step();
    drive(3'b011, 32'd9, 32'd4); wait_done(lat);
    checks++; if ({hi_o, lo_o} !== {32'd1, 32'd2}) begin errors++; $display("FAIL divu_9_4 got=%h exp=0000000100000002", {hi_o, lo_o}); end
    checks++; if (div0_o !== 1'b0) begin errors++; $display("FAIL div0_clear got=%b exp=0", div0_o); end
    step();
    drive(3'b010, 32'hFFFF_FFFB, 32'd0); wait_done(lat);
    checks++; if ({hi_o, lo_o} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_neg_zero got=%h exp=fffffffbffffffff", {hi_o, lo_o}); end
    step();
  endtask

  task automatic test_div();
    int lat;
    drive(3'b010, 32'hFFFF_FFF9, 32'd2); wait_done(lat);
    checks++; if ({hi_o, lo_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2 got=%h exp=fffffffffffffffd", {hi_o, lo_o}); end
    checks++; if (div0_o !== 1'b0) begin errors++; $display("FAIL div_flag got=%b exp=0", div0_o); end
    step();
    drive(3'b010, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(lat);
    checks++; if ({hi_o, lo_o} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_m1 got=%h exp=0000000080000000", {hi_o, lo_o}); end
    checks++; if (div0_o !== 1'b0) begin errors++; $display("FAIL div_min_flag got=%b exp=0", div0_o); end
    step();
  endtask

  task automatic test_flush();
    int lat, seen;
    drive(3'b101, 32'h5678, 32'd0); step();
    drive(3'b100, 32'h1234, 32'd0); step(); start_i = 1'b0;
    checks++; if ({hi_o, lo_o} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL mthi_mtlo got=%h exp=0000123400005678", {hi_o, lo_o}); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL mt_flags got=%b%b exp=00", busy_o, done_o); end
    drive(3'b110, 32'hBAD, 32'd1); step(); start_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || {hi_o, lo_o} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL nop_op got=%b %h", busy_o, {hi_o, lo_o}); end
    drive(3'b000, 32'd5, 32'd6); step(); start_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_rise got=%b exp=1", busy_o); end
    drive(3'b101, 32'hDEAD, 32'd0); step(); start_i = 1'b0;
    repeat (7) step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b exp=0", busy_o); end
    seen = 0;
    repeat (40) begin step(); if (done_o) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_nodone got=%0d exp=0", seen); end
    checks++; if ({hi_o, lo_o} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL flush_hold got=%h exp=0000123400005678", {hi_o, lo_o}); end
    drive(3'b001, 32'd3, 32'd4); flush_i = 1'b1; step(); flush_i = 1'b0;
    wait_done(lat);
    checks++; if (lat !== 33 || lo_o !== 32'd12) begin errors++; $display("FAIL flush_start got lat=%0d lo=%h exp lat=33 lo=c", lat, lo_o); end
  endtask

  task automatic test_back_to_back();
    int lat;
    step();
    drive(3'b010, 32'd100, 32'hFFFF_FFF9); wait_done(lat);
    checks++; if ({hi_o, lo_o} !== {32'd2, 32'hFFFF_FFF2}) begin errors++; $display("FAIL b2b_div got=%h exp=00000002fffffff2", {hi_o, lo_o}); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_reset_mid();
    int lat;
    step();
    drive(3'b000, 32'd9, 32'd9); step(); start_i = 1'b0;
    repeat (5) step();
    #2 rst = 1'b1; #1;
    checks++; if ({busy_o, done_o, div0_o} !== 3'b000 || {hi_o, lo_o} !== 64'h0) begin errors++; $display("FAIL async_reset got=%b %h exp=000 0", {busy_o, done_o, div0_o}, {hi_o, lo_o}); end
    drive(3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFB);
    #1 rst = 1'b0;
    wait_done(lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL post_reset_latency got=%0d exp=34", lat); end
    checks++; if ({hi_o, lo_o} !== {32'h0, 32'd20}) begin errors++; $display("FAIL post_reset_mult got=%h exp=0000000000000014", {hi_o, lo_o}); end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 3'b000; rs_i = '0; rt_i = '0;
    test_reset();
    test_mult();
    test_div0();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI/LO (even, >=8).
REQ-002 SHALL have clk_i  input  1  single clock, all state on the rising edge.
REQ-003 SHALL have rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have start_i  input  1  request; sampled only when busy_o=0.
REQ-005 SHALL have op_i  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 SHALL have rs_i  input  WIDTH  source 1 (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 SHALL have rt_i  input  WIDTH  source 2 (multiplier or divisor).
REQ-008 SHALL have flush_i  input  1  cancels an in-flight operation.
REQ-009 SHALL have busy_o  output  1  high while an operation is in progress.
REQ-010 SHALL have done_o  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-011 SHALL have div0_o  output  1  sticky flag: the last DIV/DIVU had a zero divisor.
REQ-012 SHALL have hi_o  output  WIDTH  HI register.
REQ-013 SHALL have lo_o  output  WIDTH  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and FIX.
REQ-015 SHALL, in IDLE, on start_i=1 with a MULT/DIV op: latch operand magnitudes, signs, op and div0; clear the step counter; go to CALC; raise busy_o from the next cycle.
REQ-016 SHALL perform exactly WIDTH radix-2 steps in CALC: shift-add for multiply, restoring shift-subtract for divide, one step per cycle; then go to FIX.
REQ-017 SHALL, in FIX, apply sign correction (negate product if signs differ; negate quotient if signs differ; remainder takes the dividend's sign), write HI/LO, pulse done_o for one cycle, return to IDLE with busy_o low.
REQ-018 SHALL therefore raise done_o exactly WIDTH+2 cycles after the start_i accept edge; a new start_i SHALL be accepted in the cycle after done_o.
REQ-019 SHALL write HI=product[2W-1:W] and LO=product[W-1:0] for multiply; HI=remainder and LO=quotient for divide.
REQ-020 SHALL treat MULTU/DIVU operands as unsigned and MULT/DIV operands as two's complement.
REQ-021 SHALL, for a zero divisor, still take full latency and set HI=rs_i, LO=all ones, div0_o=1; any non-zero-divisor divide SHALL clear div0_o.
REQ-022 SHALL, for signed MIN/-1, give LO=MIN and HI=0, with no flag.
REQ-023 SHALL, for MTHI/MTLO with start_i in IDLE, write HI or LO on the next edge, with no busy_o and no done_o.
REQ-024 SHALL ignore start_i while busy_o=1; op 11x SHALL be ignored.
REQ-025 SHALL, on flush_i=1 in CALC or FIX, return to IDLE on the next edge with HI/LO/div0_o unchanged and no done_o; flush_i SHALL take priority over the FIX write.
REQ-026 SHALL ensure flush_i in IDLE has no effect, and flush_i together with start_i in IDLE accepts the start.

Reset
REQ-027 SHALL, on rst_i asserted at any time including mid-operation, immediately force IDLE, busy_o=0, done_o=0, div0_o=0, hi_o=0, lo_o=0 and step counter 0.
REQ-028 SHALL accept start_i on the first rising edge after rst_i deasserts.

Structure
REQ-029 SHALL place op encodings, the FSM state typedef and the step-counter width ($clog2(WIDTH)+1) in shared package muldiv_pkg.
REQ-030 SHALL instantiate one sub-module, muldiv_negate (conditional two's-complement negate, parametrised width), for operand magnitude and result sign fix.
REQ-031 SHALL use one shared WIDTH+1-bit adder/subtractor for both multiply and divide steps.

Verification (WIDTH=32)
REQ-032 SHALL cover MULT rs=-3, rt=7 -> done_o at start+34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 SHALL cover DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL cover DIVU 100/0 -> HI=0x64, LO=0xFFFFFFFF, div0_o=1; a following DIVU 9/4 -> LO=2, HI=1, div0_o=0.
REQ-036 SHALL cover MTHI 0x1234 then MULT started with a flush at cycle 10 -> no done_o, HI=0x1234, and a start_i during busy is ignored.
REQ-037 SHALL cover rst_i asserted mid-CALC -> all outputs 0 asynchronously, and a new MULT completes correctly afterwards.
